// File: rtl/synth_pkg.sv
// synth_pkg: shared definitions for the synth voice path.
//   - MIDI status nibbles and controller numbers used by the voice allocator
//   - note / velocity types (7-bit MIDI data values)
//   - midi_msg_t: one decoded channel message (status nibble + two data bytes)
//   - decode_msg: classifies a message into the events the allocator acts on
package synth_pkg;

   localparam logic [3:0] NOTE_OFF         = 4'h8;
   localparam logic [3:0] NOTE_ON          = 4'h9;
   localparam logic [3:0] CTRL_CHANGE      = 4'hB;
   localparam logic [6:0] CC_ALL_NOTES_OFF = 7'd123;

   typedef logic [6:0] note_t;
   typedef logic [6:0] velocity_t;

   typedef struct packed {
      logic [3:0] status;
      note_t      d1;
      velocity_t  d2;
   } midi_msg_t;

   typedef enum logic [1:0] {
      EV_NONE,
      EV_NOTE_ON,
      EV_NOTE_OFF,
      EV_ALL_OFF
   } midi_event_t;

   // Note-on with velocity 0 is the running-status form of note-off.
   function automatic midi_event_t decode_msg(input midi_msg_t m);
      midi_event_t ev;
      ev = EV_NONE;
      if (m.status == NOTE_ON && m.d2 != '0)
         ev = EV_NOTE_ON;
      else if (m.status == NOTE_OFF || m.status == NOTE_ON)
         ev = EV_NOTE_OFF;
      else if (m.status == CTRL_CHANGE && m.d1 == CC_ALL_NOTES_OFF)
         ev = EV_ALL_OFF;
      return ev;
   endfunction

endpackage

// File: rtl/voice_age_tracker.sv
// voice_age_tracker: keeps an age rank per voice (0 = most recently
// triggered, NUM_VOICES-1 = oldest). Ranks always form a permutation.
//   clk_in        system clock
//   rst_in        synchronous active-high reset; rank[i] <- i
//   promote_valid promote promote_idx this cycle
//   promote_idx   voice to make newest
//   oldest_idx    voice currently holding rank NUM_VOICES-1 (combinational)
module voice_age_tracker #(
   parameter  int NUM_VOICES = 4,
   localparam int VW         = $clog2(NUM_VOICES)
) (
   input  logic          clk_in,
   input  logic          rst_in,
   input  logic          promote_valid,
   input  logic [VW-1:0] promote_idx,
   output logic [VW-1:0] oldest_idx
);

   logic [NUM_VOICES-1:0][VW-1:0] rank;
   logic [VW-1:0]                 promote_rank;

   assign promote_rank = rank[promote_idx];

   // Voices younger than the promoted one age by one step; older voices
   // keep their rank, so the permutation is preserved.
   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         for (int i = 0; i < NUM_VOICES; i++)
            rank[i] <= VW'(i);
      end else if (promote_valid) begin
         for (int i = 0; i < NUM_VOICES; i++) begin
            if (VW'(i) == promote_idx)
               rank[i] <= '0;
            else if (rank[i] < promote_rank)
               rank[i] <= rank[i] + 1'b1;
         end
      end
   end

   always_comb begin
      oldest_idx = '0;
      for (int i = 0; i < NUM_VOICES; i++)
         if (rank[i] == VW'(NUM_VOICES - 1))
            oldest_idx = VW'(i);
   end

endmodule

// File: rtl/voice_allocator.sv
// voice_allocator: assigns MIDI note-on events to oscillator voices.
// Retriggers a voice already holding the note, else takes the lowest free
// voice, else steals the oldest voice. Note-off gates off the holding voice;
// all-notes-off gates off every voice. All outputs are registered, 1 cycle
// after valid_in.
//   clk_in, rst_in   clock, synchronous active-high reset
//   status           MIDI status nibble
//   data_byte1/2     data bytes (bit 7 ignored)
//   valid_in         message strobe
//   voice_active     per-voice gate
//   voice_note       per-voice note number
//   voice_velocity   per-voice velocity
//   voice_trigger    per-voice one-cycle (re)start strobe
//   steal_out        one-cycle strobe: the allocation stole an active voice
module voice_allocator
   import synth_pkg::*;
#(
   parameter  int NUM_VOICES = 4,
   localparam int VW         = $clog2(NUM_VOICES)
) (
   input  logic                            clk_in,
   input  logic                            rst_in,
   input  logic [3:0]                      status,
   input  logic [7:0]                      data_byte1,
   input  logic [7:0]                      data_byte2,
   input  logic                            valid_in,
   output logic [NUM_VOICES-1:0]           voice_active,
   output logic [NUM_VOICES-1:0][6:0]      voice_note,
   output logic [NUM_VOICES-1:0][6:0]      voice_velocity,
   output logic [NUM_VOICES-1:0]           voice_trigger,
   output logic                            steal_out
);

   midi_msg_t   msg;
   midi_event_t ev;
   logic        unused_data_msb;

   logic          hit;
   logic [VW-1:0] hit_idx;
   logic          free_found;
   logic [VW-1:0] free_idx;
   logic [VW-1:0] oldest_idx;
   logic [VW-1:0] sel_idx;
   logic          steal;

   assign msg             = '{status: status, d1: data_byte1[6:0], d2: data_byte2[6:0]};
   assign unused_data_msb = data_byte1[7] ^ data_byte2[7];

   always_comb begin
      ev = EV_NONE;
      if (valid_in)
         ev = decode_msg(msg);
   end

   // Note match among gated voices and lowest-index free voice.
   always_comb begin
      hit        = 1'b0;
      hit_idx    = '0;
      free_found = 1'b0;
      free_idx   = '0;
      for (int i = 0; i < NUM_VOICES; i++) begin
         if (!hit && voice_active[i] && voice_note[i] == msg.d1) begin
            hit     = 1'b1;
            hit_idx = VW'(i);
         end
         if (!free_found && !voice_active[i]) begin
            free_found = 1'b1;
            free_idx   = VW'(i);
         end
      end
   end

   always_comb begin
      steal   = 1'b0;
      sel_idx = oldest_idx;
      if (hit)
         sel_idx = hit_idx;
      else if (free_found)
         sel_idx = free_idx;
      else
         steal = 1'b1;
   end

   voice_age_tracker #(.NUM_VOICES(NUM_VOICES)) u_age (
      .clk_in        (clk_in),
      .rst_in        (rst_in),
      .promote_valid (ev == EV_NOTE_ON),
      .promote_idx   (sel_idx),
      .oldest_idx    (oldest_idx)
   );

   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         voice_active   <= '0;
         voice_note     <= '0;
         voice_velocity <= '0;
         voice_trigger  <= '0;
         steal_out      <= 1'b0;
      end else begin
         voice_trigger <= '0;
         steal_out     <= 1'b0;
         case (ev)
            EV_NOTE_ON: begin
               voice_active[sel_idx]   <= 1'b1;
               voice_note[sel_idx]     <= msg.d1;
               voice_velocity[sel_idx] <= msg.d2;
               voice_trigger[sel_idx]  <= 1'b1;
               steal_out               <= steal;
            end
            EV_NOTE_OFF: if (hit) voice_active[hit_idx] <= 1'b0;
            EV_ALL_OFF:  voice_active <= '0;
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_voice_allocator.sv
module tb_voice_allocator;

   localparam int NV = 4;

   logic              clk_in = 1'b0;
   logic              rst_in = 1'b0;
   logic [3:0]        status = '0;
   logic [7:0]        data_byte1 = '0;
   logic [7:0]        data_byte2 = '0;
   logic              valid_in = 1'b0;
   logic [NV-1:0]        voice_active;
   logic [NV-1:0][6:0]   voice_note;
   logic [NV-1:0][6:0]   voice_velocity;
   logic [NV-1:0]        voice_trigger;
   logic                 steal_out;

   int n_checks = 0;
   int n_fail   = 0;

   // reference model for the random run
   int         m_rank [NV];
   bit         m_act  [NV];
   logic [6:0] m_note [NV];
   logic [6:0] m_vel  [NV];
   logic [NV-1:0] e_trig;
   bit            e_steal;

   voice_allocator #(.NUM_VOICES(NV)) dut (
      .clk_in         (clk_in),
      .rst_in         (rst_in),
      .status         (status),
      .data_byte1     (data_byte1),
      .data_byte2     (data_byte2),
      .valid_in       (valid_in),
      .voice_active   (voice_active),
      .voice_note     (voice_note),
      .voice_velocity (voice_velocity),
      .voice_trigger  (voice_trigger),
      .steal_out      (steal_out)
   );

   always #5 clk_in = ~clk_in;

   task automatic drive(input logic [3:0] st, input logic [7:0] b1, input logic [7:0] b2);
      status = st; data_byte1 = b1; data_byte2 = b2; valid_in = 1'b1;
   endtask

   // one event; returns at the falling edge where its result is visible
   task automatic send(input logic [3:0] st, input logic [7:0] b1, input logic [7:0] b2);
      @(negedge clk_in); drive(st, b1, b2);
      @(negedge clk_in); valid_in = 1'b0;
   endtask

   task automatic do_reset();
      @(negedge clk_in); rst_in = 1'b1; valid_in = 1'b0;
      @(negedge clk_in); rst_in = 1'b0;
   endtask

   task automatic test_reset();
      do_reset();
      n_checks++;
      if (voice_active !== 4'b0000 || voice_trigger !== 4'b0000 || steal_out !== 1'b0) begin
         n_fail++; $display("FAIL reset_ctrl: act=%b trig=%b steal=%b, want 0", voice_active, voice_trigger, steal_out);
      end
      n_checks++;
      if (voice_note !== '0 || voice_velocity !== '0) begin
         n_fail++; $display("FAIL reset_data: note=%h vel=%h, want 0", voice_note, voice_velocity);
      end
      for (int i = 0; i < NV; i++) begin
         n_checks++;
         if (dut.u_age.rank[i] !== 2'(i)) begin
            n_fail++; $display("FAIL reset_rank%0d: got %0d want %0d", i, dut.u_age.rank[i], i);
         end
      end
   endtask

   task automatic test_first_note();
      do_reset();
      send(4'h9, 8'd60, 8'd100);
      n_checks++;
      if (voice_active !== 4'b0001 || voice_note[0] !== 7'd60 || voice_velocity[0] !== 7'd100) begin
         n_fail++; $display("FAIL first_note: act=%b note=%0d vel=%0d, want 0001/60/100", voice_active, voice_note[0], voice_velocity[0]);
      end
      n_checks++;
      if (voice_trigger !== 4'b0001 || steal_out !== 1'b0) begin
         n_fail++; $display("FAIL first_trig: trig=%b steal=%b, want 0001/0", voice_trigger, steal_out);
      end
      @(negedge clk_in);
      n_checks++;
      if (voice_trigger !== 4'b0000) begin
         n_fail++; $display("FAIL first_trig_pulse: trig=%b, want 0000", voice_trigger);
      end
   endtask

   task automatic test_back_to_back();
      do_reset();
      @(negedge clk_in); drive(4'h9, 8'd60, 8'd10);
      @(negedge clk_in);
      n_checks++;
      if (voice_trigger !== 4'b0001) begin
         n_fail++; $display("FAIL b2b_trig0: trig=%b, want 0001", voice_trigger);
      end
      drive(4'h9, 8'd62, 8'd11);
      @(negedge clk_in); drive(4'h9, 8'd64, 8'd12);
      @(negedge clk_in); drive(4'h9, 8'd67, 8'd13);
      @(negedge clk_in); valid_in = 1'b0;
      n_checks++;
      if (voice_active !== 4'b1111 || voice_trigger !== 4'b1000 ||
          voice_note !== {7'd67, 7'd64, 7'd62, 7'd60}) begin
         n_fail++; $display("FAIL b2b_fill: act=%b trig=%b note=%h", voice_active, voice_trigger, voice_note);
      end
      send(4'h9, 8'd72, 8'd90);
      n_checks++;
      if (steal_out !== 1'b1 || voice_trigger !== 4'b0001 || voice_note[0] !== 7'd72 || voice_velocity[0] !== 7'd90) begin
         n_fail++; $display("FAIL b2b_steal: steal=%b trig=%b note0=%0d vel0=%0d, want 1/0001/72/90",
                            steal_out, voice_trigger, voice_note[0], voice_velocity[0]);
      end
      @(negedge clk_in);
      n_checks++;
      if (steal_out !== 1'b0 || voice_trigger !== 4'b0000) begin
         n_fail++; $display("FAIL b2b_strobe_clear: steal=%b trig=%b, want 0/0000", steal_out, voice_trigger);
      end
   endtask

   task automatic test_retrigger();
      do_reset();
      send(4'h9, 8'd60, 8'd100);
      send(4'h9, 8'd60, 8'd50);
      n_checks++;
      if (voice_active !== 4'b0001 || voice_velocity[0] !== 7'd50 || voice_trigger !== 4'b0001 || steal_out !== 1'b0) begin
         n_fail++; $display("FAIL retrigger: act=%b vel0=%0d trig=%b steal=%b, want 0001/50/0001/0",
                            voice_active, voice_velocity[0], voice_trigger, steal_out);
      end
   endtask

   task automatic test_note_off();
      do_reset();
      send(4'h9, 8'd60, 8'd100);
      send(4'h8, 8'd61, 8'd64);
      n_checks++;
      if (voice_active !== 4'b0001 || voice_note[0] !== 7'd60 || voice_trigger !== 4'b0000) begin
         n_fail++; $display("FAIL off_not_held: act=%b note0=%0d trig=%b, want 0001/60/0000", voice_active, voice_note[0], voice_trigger);
      end
      send(4'h9, 8'd60, 8'd0);
      n_checks++;
      if (voice_active !== 4'b0000 || voice_note[0] !== 7'd60 || voice_velocity[0] !== 7'd100 || voice_trigger !== 4'b0000) begin
         n_fail++; $display("FAIL off_vel0: act=%b note0=%0d vel0=%0d trig=%b, want 0000/60/100/0000",
                            voice_active, voice_note[0], voice_velocity[0], voice_trigger);
      end
      send(4'h9, 8'd65, 8'd70);
      send(4'h8, 8'd65, 8'd0);
      n_checks++;
      if (voice_active !== 4'b0000 || voice_note[0] !== 7'd65) begin
         n_fail++; $display("FAIL off_status8: act=%b note0=%0d, want 0000/65", voice_active, voice_note[0]);
      end
   endtask

   task automatic test_all_notes_off();
      do_reset();
      send(4'h9, 8'd40, 8'd1);
      send(4'h9, 8'd41, 8'd2);
      send(4'h9, 8'd42, 8'd3);
      send(4'h9, 8'd43, 8'd4);
      send(4'hB, 8'd64, 8'd127);
      n_checks++;
      if (voice_active !== 4'b1111 || voice_trigger !== 4'b0000) begin
         n_fail++; $display("FAIL other_cc_ignored: act=%b trig=%b, want 1111/0000", voice_active, voice_trigger);
      end
      send(4'hB, 8'd123, 8'd0);
      n_checks++;
      if (voice_active !== 4'b0000 || voice_trigger !== 4'b0000 || voice_note[3] !== 7'd43) begin
         n_fail++; $display("FAIL all_off: act=%b trig=%b note3=%0d, want 0000/0000/43", voice_active, voice_trigger, voice_note[3]);
      end
      send(4'h9, 8'd50, 8'd20);
      n_checks++;
      if (voice_active !== 4'b0001 || voice_note[0] !== 7'd50 || voice_trigger !== 4'b0001 || steal_out !== 1'b0) begin
         n_fail++; $display("FAIL after_all_off: act=%b note0=%0d trig=%b steal=%b, want 0001/50/0001/0",
                            voice_active, voice_note[0], voice_trigger, steal_out);
      end
      // voice 0 was oldest before, now newest: 1=3,2=2,3=1 after reordering
      n_checks++;
      if (dut.u_age.rank[0] !== 2'd0 || dut.u_age.rank[1] !== 2'd3 || dut.u_age.rank[2] !== 2'd2 || dut.u_age.rank[3] !== 2'd1) begin
         n_fail++; $display("FAIL after_all_off_rank: got %0d %0d %0d %0d, want 0 3 2 1",
                            dut.u_age.rank[0], dut.u_age.rank[1], dut.u_age.rank[2], dut.u_age.rank[3]);
      end
   endtask

   task automatic test_reset_with_valid();
      send(4'h9, 8'd70, 8'd70);
      @(negedge clk_in); rst_in = 1'b1; drive(4'h9, 8'd60, 8'd100);
      @(negedge clk_in); rst_in = 1'b0; valid_in = 1'b0;
      n_checks++;
      if (voice_active !== '0 || voice_trigger !== '0 || steal_out !== 1'b0 || voice_note !== '0 || voice_velocity !== '0) begin
         n_fail++; $display("FAIL reset_drops_event: act=%b trig=%b steal=%b note=%h vel=%h, want all 0",
                            voice_active, voice_trigger, steal_out, voice_note, voice_velocity);
      end
      n_checks++;
      if (dut.u_age.rank !== {2'd3, 2'd2, 2'd1, 2'd0}) begin
         n_fail++; $display("FAIL reset_drops_rank: got %h, want e4", dut.u_age.rank);
      end
   endtask

   task automatic model_event(input logic [3:0] st, input logic [6:0] n, input logic [6:0] k);
      int v, r;
      e_trig = '0; e_steal = 1'b0;
      v = -1;
      for (int i = 0; i < NV; i++) if (v < 0 && m_act[i] && m_note[i] == n) v = i;
      if (st == 4'h9 && k != 0) begin
         if (v < 0) for (int i = 0; i < NV; i++) if (v < 0 && !m_act[i]) v = i;
         if (v < 0) begin
            for (int i = 0; i < NV; i++) if (m_rank[i] == NV - 1) v = i;
            e_steal = 1'b1;
         end
         m_act[v] = 1'b1; m_note[v] = n; m_vel[v] = k; e_trig[v] = 1'b1;
         r = m_rank[v];
         for (int i = 0; i < NV; i++) if (m_rank[i] < r) m_rank[i]++;
         m_rank[v] = 0;
      end else if (st == 4'h8 || st == 4'h9) begin
         if (v >= 0) m_act[v] = 1'b0;
      end else if (st == 4'hB && n == 7'd123) begin
         for (int i = 0; i < NV; i++) m_act[i] = 1'b0;
      end
   endtask

   task automatic model_compare(input int step);
      logic [3:0] seen;
      seen = '0;
      for (int i = 0; i < NV; i++) begin
         n_checks++;
         if (voice_active[i] !== m_act[i] || voice_note[i] !== m_note[i] || voice_velocity[i] !== m_vel[i]) begin
            n_fail++; $display("FAIL rand_voice%0d step %0d: act=%b note=%0d vel=%0d want %b/%0d/%0d",
                               i, step, voice_active[i], voice_note[i], voice_velocity[i], m_act[i], m_note[i], m_vel[i]);
         end
         n_checks++;
         if (dut.u_age.rank[i] !== 2'(m_rank[i])) begin
            n_fail++; $display("FAIL rand_rank%0d step %0d: got %0d want %0d", i, step, dut.u_age.rank[i], m_rank[i]);
         end
         seen[dut.u_age.rank[i]] = 1'b1;
      end
      n_checks++;
      if (seen !== 4'b1111) begin
         n_fail++; $display("FAIL rand_perm step %0d: ranks cover %b want 1111", step, seen);
      end
      n_checks++;
      if (voice_trigger !== e_trig || steal_out !== e_steal) begin
         n_fail++; $display("FAIL rand_strobe step %0d: trig=%b steal=%b want %b/%b", step, voice_trigger, steal_out, e_trig, e_steal);
      end
   endtask

   task automatic test_random();
      logic [3:0] st;
      logic [6:0] n, k;
      int sel;
      do_reset();
      for (int i = 0; i < NV; i++) begin
         m_rank[i] = i; m_act[i] = 1'b0; m_note[i] = '0; m_vel[i] = '0;
      end
      e_trig = '0; e_steal = 1'b0;
      for (int s = 0; s < 1000; s++) begin
         @(negedge clk_in);
         if (s > 0) model_compare(s);
         sel = $urandom_range(0, 9);
         n   = 7'(60 + $urandom_range(0, 7));
         k   = 7'($urandom_range(1, 127));
         case (sel)
            0, 1, 2, 3, 4: st = 4'h9;
            5, 6:          st = 4'h8;
            7:             begin st = 4'h9; k = 7'd0; end
            8:             begin st = 4'hB; if ($urandom_range(0, 1) == 1) n = 7'd123; end
            default:       st = 4'hE;
         endcase
         drive(st, {1'($urandom_range(0, 1)), n}, {1'($urandom_range(0, 1)), k});
         model_event(st, n, k);
      end
      @(negedge clk_in);
      valid_in = 1'b0;
      model_compare(1000);
   endtask

   initial begin
      test_reset();
      test_first_note();
      test_back_to_back();
      test_retrigger();
      test_note_off();
      test_all_notes_off();
      test_reset_with_valid();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
